// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and helpers for the UART control slice
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts at Ptr and wraps
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  output logic               Gnt_Valid,
  output logic [IDX_W-1:0]   Gnt_Idx
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 is the requester at Ptr; the lowest set bit is the winner.
  assign req_rot = NUM_REQ'({Req, Req} >> Ptr);

  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = IDX_W'(k);
      end
    end
    sum       = {1'b0, Ptr} + {1'b0, off};
    Gnt_Valid = |Req;
    Gnt_Idx   = IDX_W'((sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with start timeout
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  localparam int IDX_W        = idx_w(NUM_REQ)
) (
  input  logic                         SysClk,
  input  logic                         Rst_n,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Ack,
  output logic [NUM_REQ-1:0]           Err,
  output logic [IDX_W-1:0]             Grant_Id,
  output logic                         Arb_Busy,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  input  logic                         Tx_Busy
);

  localparam int                  CNT_W    = idx_w(START_TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  BIT0     = NUM_REQ'(1);

  arb_state_t           state, state_d;
  logic [IDX_W-1:0]     ptr, ptr_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     grant_d;
  logic [DATA_BITS-1:0] tx_data_d;
  logic                 start_d;
  logic [NUM_REQ-1:0]   ack_d, err_d;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = Req_Data[g*DATA_BITS +: DATA_BITS];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .Req       (Req),
    .Ptr       (ptr),
    .Gnt_Valid (gnt_valid),
    .Gnt_Idx   (gnt_idx)
  );

  assign Arb_Busy = (state != ARB_IDLE);

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    grant_d   = Grant_Id;
    tx_data_d = Tx_Data;
    start_d   = Transmit_Start;
    ack_d     = '0;
    err_d     = '0;
    case (state)
      ARB_IDLE: begin
        // An external user holding Tx_Busy blocks new grants.
        if (gnt_valid && !Tx_Busy) begin
          tx_data_d = req_bytes[gnt_idx];
          grant_d   = gnt_idx;
          start_d   = 1'b1;
          cnt_d     = '0;
          ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
          state_d   = ARB_START;
        end
      end
      ARB_START: begin
        if (Tx_Busy) begin
          ack_d   = BIT0 << Grant_Id;
          start_d = 1'b0;
          state_d = ARB_DRAIN;
        end else if (cnt == CNT_LAST) begin
          err_d   = BIT0 << Grant_Id;
          start_d = 1'b0;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ARB_DRAIN: begin
        if (!Tx_Busy) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr            <= '0;
      cnt            <= '0;
      Grant_Id       <= '0;
      Tx_Data        <= '0;
      Transmit_Start <= 1'b0;
      Ack            <= '0;
      Err            <= '0;
    end else begin
      ptr            <= ptr_d;
      cnt            <= cnt_d;
      Grant_Id       <= grant_d;
      Tx_Data        <= tx_data_d;
      Transmit_Start <= start_d;
      Ack            <= ack_d;
      Err            <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a UART busy model
module tb_uart_tx_arbiter;

  localparam int DB = 8;
  localparam int NR = 4;
  localparam int TO = 16;

  logic             SysClk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [NR-1:0]    Req = '0;
  logic [NR*DB-1:0] Req_Data = '0;
  logic             Tx_Busy = 1'b0;
  logic [NR-1:0]    Ack, Err;
  logic [1:0]       Grant_Id;
  logic             Arb_Busy;
  logic [DB-1:0]    Tx_Data;
  logic             Transmit_Start;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 SysClk = ~SysClk;

  uart_tx_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR), .START_TIMEOUT(TO)) dut (
    .SysClk(SysClk), .Rst_n(Rst_n), .Req(Req), .Req_Data(Req_Data),
    .Ack(Ack), .Err(Err), .Grant_Id(Grant_Id), .Arb_Busy(Arb_Busy),
    .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start), .Tx_Busy(Tx_Busy)
  );

  // UART model: 0 = busy 3 cycles after start for 20 cycles, 1 = never busy, 2 = driven by the test
  int busy_mode = 0;
  int mdl_cnt = 0;
  int mdl_hold = 0;

  always @(negedge SysClk) begin
    if (!Rst_n) begin
      mdl_cnt = 0;
      if (busy_mode != 2) Tx_Busy = 1'b0;
    end else if (busy_mode == 0) begin
      if (Tx_Busy) begin
        mdl_hold--;
        if (mdl_hold <= 0) Tx_Busy = 1'b0;
      end else if (Transmit_Start) begin
        mdl_cnt++;
        if (mdl_cnt == 3) begin
          Tx_Busy = 1'b1;
          mdl_hold = 20;
          mdl_cnt = 0;
        end
      end else begin
        mdl_cnt = 0;
      end
    end else begin
      mdl_cnt = 0;
    end
  end

  // Event logs sampled 1 time unit after each rising edge
  int               cyc = 0;
  logic             prev_ts = 1'b0;
  logic [DB-1:0]    prev_data = '0;
  int               ts_run = 0;
  int               ts_lens[$];
  int               g_id[$];
  int               g_cyc[$];
  logic [DB-1:0]    g_data[$];
  logic [NR-1:0]    g_req[$];
  logic [NR*DB-1:0] g_rd[$];
  int               a_id[$];
  int               e_id[$];
  int               e_cyc[$];
  int               viol_onehot = 0;
  int               viol_data = 0;

  always @(posedge SysClk) begin
    #1;
    cyc++;
    if (Rst_n) begin
      if ($countones(Ack | Err) > 1) viol_onehot++;
      for (int i = 0; i < NR; i++) begin
        if (Ack[i]) a_id.push_back(i);
        if (Err[i]) begin
          e_id.push_back(i);
          e_cyc.push_back(cyc);
        end
      end
      if (Transmit_Start && !prev_ts) begin
        g_id.push_back(int'(Grant_Id));
        g_cyc.push_back(cyc);
        g_data.push_back(Tx_Data);
        g_req.push_back(Req);
        g_rd.push_back(Req_Data);
      end else if (Tx_Data !== prev_data) begin
        viol_data++;
      end
    end
    if (Transmit_Start) ts_run++;
    else if (prev_ts) begin
      ts_lens.push_back(ts_run);
      ts_run = 0;
    end
    prev_ts = Transmit_Start;
    prev_data = Tx_Data;
  end

  task automatic clear_logs();
    ts_lens.delete(); g_id.delete(); g_cyc.delete(); g_data.delete();
    g_req.delete(); g_rd.delete(); a_id.delete(); e_id.delete(); e_cyc.delete();
    viol_onehot = 0; viol_data = 0;
  endtask

  task automatic do_reset();
    @(negedge SysClk);
    Rst_n = 1'b0; Req = '0; busy_mode = 0; Tx_Busy = 1'b0;
    repeat (2) @(negedge SysClk);
    Rst_n = 1'b1;
    clear_logs();
  endtask

  // Requesters drop their bit once acknowledged or errored; returns when everything is quiet.
  task automatic serve(input int maxc, input string tag);
    int used = 0;
    while (used < maxc && (Req != 0 || Arb_Busy || Tx_Busy)) begin
      @(negedge SysClk);
      Req = Req & ~(Ack | Err);
      used++;
    end
    tests_run++;
    if (used >= maxc) begin
      tests_failed++;
      $display("FAIL %s_done: still active after %0d cycles, required idle", tag, used);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!Transmit_Start && n < 20) begin
      @(negedge SysClk);
      n++;
    end
    tests_run++;
    if (!Transmit_Start) begin
      tests_failed++;
      $display("FAIL %s_start: Transmit_Start=%0b after %0d cycles, required 1", tag, Transmit_Start, n);
    end
  endtask

  task automatic test_reset();
    @(negedge SysClk);
    tests_run++;
    if ({Ack, Err, Grant_Id, Arb_Busy, Tx_Data, Transmit_Start} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: Ack=%h Err=%h Gid=%0d Busy=%0b Data=%h Start=%0b, required all 0",
               Ack, Err, Grant_Id, Arb_Busy, Tx_Data, Transmit_Start);
    end
    Rst_n = 1'b1;
    repeat (3) @(negedge SysClk);
    tests_run++;
    if (Arb_Busy !== 1'b0 || Transmit_Start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: Arb_Busy=%0b Start=%0b with no Req, required 0 0", Arb_Busy, Transmit_Start);
    end
  endtask

  task automatic test_single();
    do_reset();
    Req_Data = $urandom;
    Req_Data[2*DB +: DB] = 8'hA5;
    Req = 4'b0100;
    serve(100, "single");
    tests_run++;
    if (g_id.size() != 1 || g_id[0] != 2 || g_data[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_grant: grants=%0d id=%0d data=%h, required 1 grant id=2 data=a5",
               g_id.size(), (g_id.size() > 0) ? g_id[0] : -1, (g_data.size() > 0) ? g_data[0] : 8'h00);
    end
    tests_run++;
    if (ts_lens.size() != 1 || ts_lens[0] != 3) begin
      tests_failed++;
      $display("FAIL single_start_len: pulses=%0d len=%0d, required 1 pulse of 3 cycles",
               ts_lens.size(), (ts_lens.size() > 0) ? ts_lens[0] : -1);
    end
    tests_run++;
    if (a_id.size() != 1 || a_id[0] != 2 || e_id.size() != 0) begin
      tests_failed++;
      $display("FAIL single_ack: acks=%0d id=%0d errs=%0d, required 1 ack id=2 errs=0",
               a_id.size(), (a_id.size() > 0) ? a_id[0] : -1, e_id.size());
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
    Req = 4'b1111;
    while (g_id.size() < 5 && n < 400) begin
      @(negedge SysClk);
      n++;
    end
    Req = '0;
    serve(100, "rr");
    tests_run++;
    if (g_id.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_count: grants=%0d, required 5", g_id.size());
    end
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      tests_run++;
      if (g_id[k] != exp_order[k] || g_data[k] !== 8'(8'h10 + exp_order[k])) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: id=%0d data=%h, required id=%0d data=%h",
                 k, g_id[k], g_data[k], exp_order[k], 8'(8'h10 + exp_order[k]));
      end
    end
    tests_run++;
    if (a_id.size() != 5 || e_id.size() != 0 || viol_data != 0 || viol_onehot != 0) begin
      tests_failed++;
      $display("FAIL rr_acks: acks=%0d errs=%0d data_changes=%0d multi=%0d, required 5 0 0 0",
               a_id.size(), e_id.size(), viol_data, viol_onehot);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    busy_mode = 1;
    Req_Data = $urandom;
    Req = 4'b0011;
    serve(150, "timeout");
    tests_run++;
    if (e_id.size() != 2 || e_id[0] != 0 || e_id[1] != 1 || a_id.size() != 0) begin
      tests_failed++;
      $display("FAIL timeout_errs: errs=%0d first=%0d acks=%0d, required errs 0 then 1, no acks",
               e_id.size(), (e_id.size() > 0) ? e_id[0] : -1, a_id.size());
    end
    tests_run++;
    if (ts_lens.size() < 1 || ts_lens[0] != TO) begin
      tests_failed++;
      $display("FAIL timeout_len: start held %0d cycles, required %0d",
               (ts_lens.size() > 0) ? ts_lens[0] : -1, TO);
    end
    tests_run++;
    if (g_id.size() != 2 || e_cyc.size() < 1 || g_id[1] != 1 || g_cyc[1] - e_cyc[0] != 1) begin
      tests_failed++;
      $display("FAIL timeout_next: grants=%0d second_id=%0d gap=%0d, required id 1 one cycle after Err",
               g_id.size(), (g_id.size() > 1) ? g_id[1] : -1,
               (g_id.size() > 1 && e_cyc.size() > 0) ? g_cyc[1] - e_cyc[0] : -1);
    end
    busy_mode = 0;
  endtask

  task automatic test_busy_hold();
    int rel;
    do_reset();
    busy_mode = 2;
    Tx_Busy = 1'b1;
    Req = 4'b0001;
    repeat (10) @(negedge SysClk);
    tests_run++;
    if (g_id.size() != 0 || Transmit_Start !== 1'b0) begin
      tests_failed++;
      $display("FAIL busyhold_blocked: grants=%0d start=%0b while Tx_Busy high, required 0 0",
               g_id.size(), Transmit_Start);
    end
    busy_mode = 0;
    Tx_Busy = 1'b0;
    rel = cyc;
    serve(100, "busyhold");
    tests_run++;
    if (g_id.size() != 1 || g_id[0] != 0 || g_cyc[0] != rel + 1 || a_id.size() != 1) begin
      tests_failed++;
      $display("FAIL busyhold_grant: grants=%0d latency=%0d acks=%0d, required 1 grant of id 0 one cycle after release, 1 ack",
               g_id.size(), (g_cyc.size() > 0) ? g_cyc[0] - rel : -1, a_id.size());
    end
  endtask

  task automatic test_reset_mid();
    int acks_before;
    do_reset();
    Req_Data = $urandom;
    Req = 4'b0010;
    serve(100, "rstmid_pre");
    @(negedge SysClk);
    Req = 4'b0100;
    wait_start("rstmid");
    acks_before = a_id.size();
    Rst_n = 1'b0;
    #1;
    tests_run++;
    if ({Transmit_Start, Ack, Err, Arb_Busy} !== '0 || Grant_Id !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: Start=%0b Ack=%h Err=%h Busy=%0b Gid=%0d, required all 0",
               Transmit_Start, Ack, Err, Arb_Busy, Grant_Id);
    end
    Req = '0;
    repeat (3) @(negedge SysClk);
    Rst_n = 1'b1;
    repeat (2) @(negedge SysClk);
    tests_run++;
    if (a_id.size() != acks_before || e_id.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_noack: acks=%0d errs=%0d, required %0d 0", a_id.size(), e_id.size(), acks_before);
    end
    clear_logs();
    Req = 4'b1001;
    serve(100, "rstmid_ptr");
    tests_run++;
    if (g_id.size() < 1 || g_id[0] != 0) begin
      tests_failed++;
      $display("FAIL rstmid_ptr0: first grant %0d, required 0", (g_id.size() > 0) ? g_id[0] : -1);
    end
    clear_logs();
    Req = 4'b1000;
    serve(100, "rstmid_r3");
    tests_run++;
    if (g_id.size() != 1 || g_id[0] != 3 || a_id.size() != 1) begin
      tests_failed++;
      $display("FAIL rstmid_grant3: grants=%0d id=%0d acks=%0d, required 1 grant id 3 and 1 ack",
               g_id.size(), (g_id.size() > 0) ? g_id[0] : -1, a_id.size());
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    Req_Data = $urandom;
    Req_Data[1*DB +: DB] = 8'h5A;
    Req = 4'b0010;
    wait_start("withdraw");
    Req[1] = 1'b0;
    Req_Data[1*DB +: DB] = 8'hC3;
    serve(100, "withdraw");
    tests_run++;
    if (g_data.size() != 1 || g_data[0] !== 8'h5A || viol_data != 0) begin
      tests_failed++;
      $display("FAIL withdraw_data: grants=%0d data=%h changes=%0d, required 1 grant data 5a, 0 changes",
               g_data.size(), (g_data.size() > 0) ? g_data[0] : 8'h00, viol_data);
    end
    tests_run++;
    if (a_id.size() != 1 || a_id[0] != 1 || e_id.size() != 0) begin
      tests_failed++;
      $display("FAIL withdraw_ack: acks=%0d id=%0d errs=%0d, required 1 ack id 1, 0 errs",
               a_id.size(), (a_id.size() > 0) ? a_id[0] : -1, e_id.size());
    end
  endtask

  task automatic test_random();
    int ptr = 0;
    int exp_id;
    logic [NR-1:0]    rq;
    logic [NR*DB-1:0] rd;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      @(negedge SysClk);
      Req = Req & ~(Ack | Err);
      for (int i = 0; i < NR; i++) begin
        if (!Req[i] && $urandom_range(0, 3) == 0) begin
          Req_Data[i*DB +: DB] = 8'($urandom);
          Req[i] = 1'b1;
        end
      end
    end
    Req = '0;
    serve(100, "random");
    // Reference: winner is the first requester at or after the pointer, pointer moves past it.
    for (int k = 0; k < g_id.size(); k++) begin
      rq = g_req[k];
      rd = g_rd[k];
      exp_id = -1;
      for (int s = 0; s < NR && exp_id < 0; s++) begin
        if (rq[(ptr + s) % NR]) exp_id = (ptr + s) % NR;
      end
      tests_run++;
      if (exp_id < 0 || g_id[k] != exp_id || g_data[k] !== rd[exp_id*DB +: DB]) begin
        tests_failed++;
        $display("FAIL random_grant%0d: id=%0d data=%h req=%b, required id=%0d data=%h",
                 k, g_id[k], g_data[k], rq, exp_id, (exp_id >= 0) ? rd[exp_id*DB +: DB] : 8'h00);
      end
      if (exp_id >= 0) ptr = (exp_id + 1) % NR;
    end
    tests_run++;
    if (g_id.size() < 10 || a_id.size() != g_id.size() || e_id.size() != 0) begin
      tests_failed++;
      $display("FAIL random_acks: grants=%0d acks=%0d errs=%0d, required >=10 grants, equal acks, 0 errs",
               g_id.size(), a_id.size(), e_id.size());
    end
    for (int k = 0; k < a_id.size() && k < g_id.size(); k++) begin
      tests_run++;
      if (a_id[k] != g_id[k]) begin
        tests_failed++;
        $display("FAIL random_ack%0d: ack id=%0d, required %0d", k, a_id[k], g_id[k]);
      end
    end
    tests_run++;
    if (viol_data != 0 || viol_onehot != 0) begin
      tests_failed++;
      $display("FAIL random_invariants: data_changes=%0d multi_pulse=%0d, required 0 0", viol_data, viol_onehot);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
